fetch_unit: RTL and testbench

- IF stage of the 8-bit pipeline: owns the PC, drives the instruction-memory address, assembles 2-byte instructions, and holds the IF/ID pipeline register.
- Consumes the hazard controls stall_F, stall_D and flush_D, plus redirects from EX (branch) and WB (RET/RTI).
- Produces is_2byte_D, which the hazard logic uses to freeze the front end for one cycle.
- On reset, loads the start PC from the boot vector in instruction memory.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/if_id_reg.sv | 74 +++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, instruction-length table and fetch FSM encoding
package cpu_pkg;

    // Opcode classes occupy opcode[7:4]
    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ALU   = 4'h1;
    localparam logic [3:0] OPC_LDI   = 4'h2;
    localparam logic [3:0] OPC_LD    = 4'h3;
    localparam logic [3:0] OPC_ST    = 4'h4;
    localparam logic [3:0] OPC_ALUI  = 4'h5;
    localparam logic [3:0] OPC_STACK = 4'h6;
    localparam logic [3:0] OPC_SHIFT = 4'h7;
    localparam logic [3:0] OPC_JMP   = 4'h8;
    localparam logic [3:0] OPC_CALL  = 4'h9;
    localparam logic [3:0] OPC_BR    = 4'hA;
    localparam logic [3:0] OPC_LOOP  = 4'hB;
    localparam logic [3:0] OPC_RET   = 4'hC;
    localparam logic [3:0] OPC_IO    = 4'hD;

    localparam logic [7:0] NOP_OPCODE_DEF = 8'h00;

    // Bit n set means opcode class n carries an immediate/address byte:
    // LDI, LD, ST, ALUI (2..5) and JMP, CALL, BR, LOOP (8..11).
    localparam logic [15:0] TWO_BYTE_MASK = 16'h0F3C;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // True when the opcode is followed by a second instruction byte
    function automatic logic is_two_byte(input logic [7:0] opcode);
        return TWO_BYTE_MASK[opcode[7:4]];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, load and immediate-capture controls
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [7:0] NOP_OPCODE = NOP_OPCODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       load,
    input  logic       cap,
    input  logic [7:0] fetch_byte,
    input  logic [7:0] fetch_pc,
    output logic [7:0] instr,
    output logic [7:0] imm,
    output logic       imm_valid,
    output logic       valid,
    output logic [7:0] ret_addr
);

    logic [7:0] instr_q, instr_d;
    logic [7:0] imm_q, imm_d;
    logic       imm_valid_q, imm_valid_d;
    logic       valid_q, valid_d;
    logic [7:0] ret_addr_q, ret_addr_d;

    // Next-state of the register: flush beats load beats capture, else hold
    always_comb begin
        instr_d     = instr_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        valid_d     = valid_q;
        ret_addr_d  = ret_addr_q;
        if (flush) begin
            instr_d     = NOP_OPCODE;
            valid_d     = 1'b0;
            imm_valid_d = 1'b0;
        end else if (load) begin
            instr_d     = fetch_byte;
            valid_d     = 1'b1;
            imm_valid_d = 1'b0;
            ret_addr_d  = fetch_pc + 8'd1;
        end else if (cap) begin
            // fetch_pc points at the immediate, so +1 is the opcode address + 2
            imm_d       = fetch_byte;
            imm_valid_d = 1'b1;
            ret_addr_d  = fetch_pc + 8'd1;
        end
    end

    // Register state with asynchronous reset to an empty NOP slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= NOP_OPCODE;
            imm_q       <= 8'h00;
            imm_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            ret_addr_q  <= 8'h00;
        end else begin
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            valid_q     <= valid_d;
            ret_addr_q  <= ret_addr_d;
        end
    end

    assign instr     = instr_q;
    assign imm       = imm_q;
    assign imm_valid = imm_valid_q;
    assign valid     = valid_q;
    assign ret_addr  = ret_addr_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, boot-vector load, 2-byte assembly and IF/ID register
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] BOOT_VEC_ADDR = 8'h00,
    parameter bit         USE_BOOT_VEC  = 1'b1,
    parameter logic [7:0] NOP_OPCODE    = NOP_OPCODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_F,
    input  logic       stall_D,
    input  logic       flush_D,
    input  logic       branch_taken_E,
    input  logic [7:0] branch_target_E,
    input  logic       ret_load_W,
    input  logic [7:0] ret_pc_W,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    output logic [7:0] pc_F,
    output logic [7:0] instr_D,
    output logic [7:0] imm_D,
    output logic       imm_valid_D,
    output logic [7:0] ret_addr_D,
    output logic       valid_D,
    output logic       is_2byte_D
);

    localparam fetch_state_t RESET_STATE = USE_BOOT_VEC ? ST_BOOT : ST_RUN;

    fetch_state_t state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic         in_run;
    logic         cap;
    logic         redirect;

    assign in_run   = (state_q == ST_RUN);
    assign redirect = ret_load_W | branch_taken_E;

    // Opcode waiting for its second byte; valid_D is low throughout BOOT
    assign is_2byte_D = valid_D & is_two_byte(instr_D) & ~imm_valid_D;

    // A redirect in the capture cycle kills the capture; the hazard unit flushes it
    assign cap = in_run & is_2byte_D & ~flush_D & ~redirect;

    // BOOT reads the vector slot; afterwards memory follows the PC
    assign imem_addr = in_run ? pc_q : BOOT_VEC_ADDR;
    assign pc_F      = pc_q;

    // Next PC and state: boot load, then return > branch > capture > advance > hold
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (!in_run) begin
            pc_d    = imem_rdata;
            state_d = ST_RUN;
        end else if (ret_load_W) begin
            pc_d = ret_pc_W;
        end else if (branch_taken_E) begin
            pc_d = branch_target_E;
        end else if (cap || stall_F) begin
            // capture advances even with stall_F low: that freeze exists for it
            pc_d = pc_q + 8'd1;
        end
    end

    // Fetch FSM and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            pc_q    <= BOOT_VEC_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_OPCODE(NOP_OPCODE)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (in_run & flush_D),
        .load       (in_run & stall_D),
        .cap        (cap),
        .fetch_byte (imem_rdata),
        .fetch_pc   (pc_q),
        .instr      (instr_D),
        .imm        (imm_D),
        .imm_valid  (imm_valid_D),
        .valid      (valid_D),
        .ret_addr   (ret_addr_D)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall_F, stall_D, flush_D;
    logic       branch_taken_E, ret_load_W;
    logic [7:0] branch_target_E, ret_pc_W;
    logic [7:0] imem_addr, imem_rdata;
    logic [7:0] pc_F, instr_D, imm_D, ret_addr_D;
    logic       imm_valid_D, valid_D, is_2byte_D;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .flush_D         (flush_D),
        .branch_taken_E  (branch_taken_E),
        .branch_target_E (branch_target_E),
        .ret_load_W      (ret_load_W),
        .ret_pc_W        (ret_pc_W),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_F            (pc_F),
        .instr_D         (instr_D),
        .imm_D           (imm_D),
        .imm_valid_D     (imm_valid_D),
        .ret_addr_D      (ret_addr_D),
        .valid_D         (valid_D),
        .is_2byte_D      (is_2byte_D)
    );

    logic [7:0] imem [256];
    assign imem_rdata = imem[imem_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the IF stage should hold after each edge
    bit         m_boot;
    logic [7:0] m_pc, m_instr, m_imm, m_ret;
    bit         m_immv, m_valid;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Opcode classes with an immediate: LDI/LD/ST/ALUI and JMP/CALL/BR/LOOP
    function automatic bit has_imm(input logic [7:0] op);
        return op[7:4] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic bit model_is2();
        return m_valid && has_imm(m_instr) && !m_immv;
    endfunction

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 8'h00;
        m_instr = 8'h00;
        m_imm   = 8'h00;
        m_immv  = 1'b0;
        m_valid = 1'b0;
        m_ret   = 8'h00;
    endtask

    task automatic model_advance(input bit sF, input bit sD, input bit fl, input bit br,
                                 input logic [7:0] bt, input bit rl, input logic [7:0] rp);
        logic [7:0] fetched;
        logic [7:0] next_pc;
        bit         capture;
        if (m_boot) begin
            m_pc   = imem[8'h00];
            m_boot = 1'b0;
        end else begin
            fetched = imem[m_pc];
            capture = model_is2() && !fl && !br && !rl;
            if (rl)                 next_pc = rp;
            else if (br)            next_pc = bt;
            else if (capture || sF) next_pc = m_pc + 8'd1;
            else                    next_pc = m_pc;
            if (fl) begin
                m_instr = 8'h00;
                m_valid = 1'b0;
                m_immv  = 1'b0;
            end else if (sD) begin
                m_instr = fetched;
                m_valid = 1'b1;
                m_immv  = 1'b0;
                m_ret   = m_pc + 8'd1;
            end else if (capture) begin
                m_imm  = fetched;
                m_immv = 1'b1;
                m_ret  = m_pc + 8'd1;
            end
            m_pc = next_pc;
        end
    endtask

    task automatic compare_all();
        check_eq("imem_addr", imem_addr, m_boot ? 8'h00 : m_pc);
        check_eq("pc_F", pc_F, m_pc);
        check_eq("instr_D", instr_D, m_instr);
        check_eq("imm_D", imm_D, m_imm);
        check_eq("imm_valid_D", {7'b0, imm_valid_D}, {7'b0, m_immv});
        check_eq("valid_D", {7'b0, valid_D}, {7'b0, m_valid});
        check_eq("ret_addr_D", ret_addr_D, m_ret);
        check_eq("is_2byte_D", {7'b0, is_2byte_D}, {7'b0, model_is2()});
    endtask

    task automatic step(input bit sF, input bit sD, input bit fl, input bit br,
                        input logic [7:0] bt, input bit rl, input logic [7:0] rp);
        stall_F         = sF;
        stall_D         = sD;
        flush_D         = fl;
        branch_taken_E  = br;
        branch_target_E = bt;
        ret_load_W      = rl;
        ret_pc_W        = rp;
        model_advance(sF, sD, fl, br, bt, rl, rp);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_step();
        bit         sF, sD, fl, br, rl;
        logic [7:0] bt, rp;
        sF = ($urandom_range(0, 3) != 0);
        sD = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 5) == 0);
        br = ($urandom_range(0, 7) == 0);
        rl = ($urandom_range(0, 9) == 0);
        bt = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        rp = 8'($urandom);
        step(sF, sD, fl, br, bt, rl, rp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        imem[8'h00] = 8'h10;
        imem[8'h10] = 8'h01;
        imem[8'h20] = 8'h20;
        imem[8'h21] = 8'hAB;

        rst_n = 1'b0;
        stall_F = 0; stall_D = 0; flush_D = 0;
        branch_taken_E = 0; branch_target_E = 0; ret_load_W = 0; ret_pc_W = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        #1 compare_all();

        // Boot vector, then first 1-byte instruction
        step(0, 0, 0, 0, 8'h00, 0, 8'h00);
        check_eq("boot_pc", pc_F, 8'h10);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00);
        check_eq("first_instr", instr_D, 8'h01);
        check_eq("first_ret", ret_addr_D, 8'h11);

        // 2-byte capture at 0x20
        step(1, 1, 1, 1, 8'h20, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00);
        check_eq("is2_set", {7'b0, is_2byte_D}, 8'h01);
        step(0, 0, 0, 0, 8'h00, 0, 8'h00);
        check_eq("cap_imm", imm_D, 8'hAB);
        check_eq("cap_pc", pc_F, 8'h22);
        check_eq("cap_ret", ret_addr_D, 8'h22);

        // Branch in the capture cycle wins; no capture
        step(1, 1, 1, 1, 8'h20, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00);
        step(0, 0, 1, 1, 8'h40, 0, 8'h00);
        check_eq("br_pc", pc_F, 8'h40);
        check_eq("br_immv", {7'b0, imm_valid_D}, 8'h00);

        // RET bubble then return beating a simultaneous branch
        repeat (3) step(0, 1, 1, 0, 8'h00, 0, 8'h00);
        check_eq("ret_frozen_pc", pc_F, 8'h40);
        step(0, 1, 1, 1, 8'h50, 1, 8'h33);
        check_eq("ret_pc", pc_F, 8'h33);

        // Wrap and load-use hold
        step(0, 0, 1, 0, 8'h00, 1, 8'hFF);
        step(1, 0, 1, 0, 8'h00, 0, 8'h00);
        check_eq("wrap_pc", pc_F, 8'h00);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 0, 8'h00);
        check_eq("hold_pc", pc_F, 8'h01);
        check_eq("hold_instr", instr_D, 8'h10);

        repeat (1500) rand_step();

        // Asynchronous reset while a capture is pending
        for (int i = 0; i < 300 && !model_is2(); i++) rand_step();
        check_eq("pre_reset_is_2byte", {7'b0, is_2byte_D}, 8'h01);
        stall_F = 0; stall_D = 0; flush_D = 0; branch_taken_E = 0; ret_load_W = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        #1 compare_all();

        repeat (800) rand_step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
